// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target engine.
package i2c_slave_pkg;
  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  // Bus levels for the acknowledge bit.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_slave_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample glitch filter for one bus line.
module i2c_slave_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);
  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  // Lines idle high, so everything resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      filt  <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == 4'(FILTER_LEN - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/i2c_slave.sv
// I2C target engine: 7-bit address, one-byte register pointer, burst read/write.
// Optional clock stretching on reads is enabled with I2C_SLAVE_STRETCH_EN.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [ADDR_W-1:0] own_addr_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_o,
  output logic              sda_o,
  output logic              scl_oe_o,
  output logic              sda_oe_o,
  output logic [BYTE_W-1:0] reg_ptr_o,
  output logic              wr_valid_o,
  output logic [BYTE_W-1:0] wdata_o,
  output logic              rd_req_o,
  input  logic [BYTE_W-1:0] rdata_i,
  input  logic              rdata_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output state_t            state_o
);
  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] byte_in;
  logic              rw;
  logic              phase;
  logic [BYTE_W-1:0] reg_ptr, wdata;
  logic              wr_valid, rd_req, busy, done, sda_oe;

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk (clk_i),
    .rst (rst_i),
    .raw (scl_i),
    .filt(scl_f)
  );

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk (clk_i),
    .rst (rst_i),
    .raw (sda_i),
    .filt(sda_f)
  );

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign byte_in   = {shreg[BYTE_W-2:0], sda_f};

`ifdef I2C_SLAVE_STRETCH_EN
  logic scl_hold;
  logic stretch_pend;
  assign scl_oe_o = scl_hold;
`else
  logic unused_rdata_valid;
  assign unused_rdata_valid = rdata_valid_i;
  assign scl_oe_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      phase    <= 1'b0;
      reg_ptr  <= '0;
      wdata    <= '0;
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sda_oe   <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_hold     <= 1'b0;
      stretch_pend <= 1'b0;
`endif
    end else begin
      scl_d    <= scl_f;
      sda_d    <= sda_f;
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      done     <= 1'b0;

`ifdef I2C_SLAVE_STRETCH_EN
      // Hold SCL low after the next falling edge until the read byte arrives.
      if (!enable_i || stop_det || start_det) begin
        scl_hold     <= 1'b0;
        stretch_pend <= 1'b0;
      end else begin
        if (rd_req) stretch_pend <= 1'b1;
        if (stretch_pend && scl_fall) scl_hold <= 1'b1;
        if (scl_hold && rdata_valid_i) begin
          shreg        <= rdata_i;
          scl_hold     <= 1'b0;
          stretch_pend <= 1'b0;
          if (state == S_RDATA && bit_cnt == 4'd0) sda_oe <= ~rdata_i[BYTE_W-1];
        end
      end
`else
      if (rd_req) shreg <= rdata_i;
`endif

      if (!enable_i) begin
        state   <= S_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
        phase   <= 1'b0;
      end else if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        done   <= busy;
        phase  <= 1'b0;
      end else if (start_det) begin
        state   <= S_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        phase   <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (shreg[ADDR_W-1:0] == own_addr_i) begin
                  state  <= S_ADDR_ACK;
                  busy   <= 1'b1;
                  rw     <= sda_f;
                  phase  <= 1'b0;
                  rd_req <= sda_f;
                end else begin
                  state <= S_WAIT_STOP;
                end
              end
            end
          end
          // phase 0: waiting for the fall that opens the ACK slot; phase 1: driving ACK.
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= ~ACK;
                phase  <= 1'b1;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= '0;
                if (rw) begin
                  state  <= S_RDATA;
                  sda_oe <= ~shreg[BYTE_W-1];
                end else begin
                  state  <= S_REG;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          S_REG: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                reg_ptr <= byte_in;
                state   <= S_REG_ACK;
                phase   <= 1'b0;
              end
            end
          end
          S_WDATA: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                wdata    <= byte_in;
                wr_valid <= 1'b1;
                state    <= S_WDATA_ACK;
                phase    <= 1'b0;
              end
            end
          end
          S_REG_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= ~ACK;
                phase  <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                phase   <= 1'b0;
                bit_cnt <= '0;
                state   <= S_WDATA;
                if (state == S_WDATA_ACK) reg_ptr <= reg_ptr + 8'd1;
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= S_RDATA_ACK;
                phase  <= 1'b0;
              end else begin
                sda_oe <= ~shreg[3'd7 - bit_cnt[2:0]];
              end
            end
          end
          // Master ACK fetches the next byte now; its MSB goes out on the closing fall.
          S_RDATA_ACK: begin
            if (!phase && scl_rise) begin
              if (sda_f == ACK) begin
                reg_ptr <= reg_ptr + 8'd1;
                rd_req  <= 1'b1;
                phase   <= 1'b1;
              end else begin
                state <= S_WAIT_STOP;
              end
            end else if (phase && scl_fall) begin
              phase   <= 1'b0;
              bit_cnt <= '0;
              state   <= S_RDATA;
              sda_oe  <= ~shreg[BYTE_W-1];
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign scl_o      = 1'b0;
  assign sda_o      = 1'b0;
  assign sda_oe_o   = sda_oe;
  assign reg_ptr_o  = reg_ptr;
  assign wr_valid_o = wr_valid;
  assign wdata_o    = wdata;
  assign rd_req_o   = rd_req;
  assign busy_o     = busy;
  assign done_o     = done;
  assign state_o    = state;
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged bus master, write/read scoreboards, corner-case sequences.
module tb_i2c_slave;
  import i2c_slave_pkg::*;

  localparam int H = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] own_addr = 7'h50;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_line, sda_line;
  logic       scl_o, sda_o, scl_oe, sda_oe;
  logic [7:0] reg_ptr, wdata, rdata;
  logic       wr_valid, rd_req, busy, done;
  logic       rdata_valid;
  state_t     state;

  assign scl_line    = m_scl & ~scl_oe;
  assign sda_line    = m_sda & ~sda_oe;
  assign rdata       = reg_ptr ^ 8'h1C;
  assign rdata_valid = 1'b1;

  always #5 clk = ~clk;

  i2c_slave #(.FILTER_LEN(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .own_addr_i   (own_addr),
    .scl_i        (scl_line),
    .sda_i        (sda_line),
    .scl_o        (scl_o),
    .sda_o        (sda_o),
    .scl_oe_o     (scl_oe),
    .sda_oe_o     (sda_oe),
    .reg_ptr_o    (reg_ptr),
    .wr_valid_o   (wr_valid),
    .wdata_o      (wdata),
    .rd_req_o     (rd_req),
    .rdata_i      (rdata),
    .rdata_valid_i(rdata_valid),
    .busy_o       (busy),
    .done_o       (done),
    .state_o      (state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] wr_exp_q[$];
  logic [7:0]  rd_ptr_q[$];
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, busy_cyc = 0, drive_cyc = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: strobes are popped against what the stimulus queued.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid) begin
        wr_cnt++;
        if (wr_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected write: ptr 0x%0h data 0x%0h", reg_ptr, wdata);
        end else begin
          check("write ptr/data", {reg_ptr, wdata}, wr_exp_q.pop_front());
        end
      end
      if (rd_req) begin
        rd_cnt++;
        if (rd_ptr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected read request: ptr 0x%0h", reg_ptr);
        end else begin
          check("read request ptr", 16'(reg_ptr), 16'(rd_ptr_q.pop_front()));
        end
      end
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (sda_oe) drive_cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period starting and ending with SCL low; optional low glitch mid-high.
  task automatic bit_io(input logic b, input int gl, output logic rb);
    cyc(H / 2);
    m_sda = b;
    cyc(H - H / 2);
    m_scl = 1'b1;
    if (gl > 0) begin
      cyc(3);
      m_scl = 1'b0;
      cyc(gl);
      m_scl = 1'b1;
      cyc(H - 4 - gl);
    end else begin
      cyc(H - 1);
    end
    rb = sda_line;
    cyc(1);
    m_scl = 1'b0;
  endtask

  task automatic byte_wr(input logic [7:0] b, input int gl_bit, input int gl_len,
                         output logic ack_lvl);
    logic rb;
    for (int i = 7; i >= 0; i--) bit_io(b[i], (i == gl_bit) ? gl_len : 0, rb);
    bit_io(1'b1, 0, ack_lvl);
  endtask

  task automatic byte_rd(input logic ack_out, output logic [7:0] b);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, 0, rb);
      b[i] = rb;
    end
    bit_io(ack_out, 0, rb);
  endtask

  task automatic bus_start();
    m_sda = 1'b0;
    cyc(H);
    m_scl = 1'b0;
  endtask

  task automatic bus_rstart();
    cyc(H / 2);
    m_sda = 1'b1;
    cyc(H - H / 2);
    m_scl = 1'b1;
    cyc(H);
    m_sda = 1'b0;
    cyc(H);
    m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    cyc(H / 2);
    m_sda = 1'b0;
    cyc(H - H / 2);
    m_scl = 1'b1;
    cyc(H);
    m_sda = 1'b1;
    cyc(2 * H);
  endtask

  typedef struct {
    logic [6:0]  own;
    logic [7:0]  addr_b;
    logic [7:0]  reg_b;
    int          n_data;
    logic [23:0] data;
  } wr_vec_t;

  wr_vec_t vecs[5];

  initial begin
    logic       a;
    logic       exp_ack;
    logic [7:0] rb8;
    logic       rb;
    logic [7:0] p;
    int         d0, w0, r0;

    vecs[0] = '{own: 7'h50, addr_b: 8'hA0, reg_b: 8'h10, n_data: 1, data: 24'hA50000};
    vecs[1] = '{own: 7'h50, addr_b: 8'hA0, reg_b: 8'hFF, n_data: 2, data: 24'h112200};
    vecs[2] = '{own: 7'h50, addr_b: 8'hA2, reg_b: 8'h10, n_data: 1, data: 24'h5A0000};
    vecs[3] = '{own: 7'h2A, addr_b: 8'h54, reg_b: 8'h7E, n_data: 3, data: 24'hC30FF0};
    vecs[4] = '{own: 7'h2A, addr_b: 8'hA0, reg_b: 8'h10, n_data: 1, data: 24'h660000};

    // Reset state
    cyc(3);
    check("reset sda_oe", 16'(sda_oe), 16'h0);
    check("reset scl_oe", 16'(scl_oe), 16'h0);
    check("reset scl_o", 16'(scl_o), 16'h0);
    check("reset sda_o", 16'(sda_o), 16'h0);
    check("reset reg_ptr", 16'(reg_ptr), 16'h0);
    check("reset wdata", 16'(wdata), 16'h0);
    check("reset strobes", 16'({wr_valid, rd_req, busy, done}), 16'h0);
    check("reset state", 16'(state), 16'(S_IDLE));
    rst = 1'b0;
    cyc(2);
    enable = 1'b1;
    cyc(5);

    // Table-driven writes
    for (int k = 0; k < 5; k++) begin
      own_addr = vecs[k].own;
      cyc(2);
      exp_ack   = (vecs[k].addr_b[7:1] == vecs[k].own) && !vecs[k].addr_b[0];
      d0        = done_cnt;
      busy_cyc  = 0;
      drive_cyc = 0;
      if (exp_ack) begin
        for (int j = 0; j < vecs[k].n_data; j++) begin
          p = vecs[k].reg_b + 8'(j);
          wr_exp_q.push_back({p, vecs[k].data[23 - 8 * j -: 8]});
        end
      end
      bus_start();
      byte_wr(vecs[k].addr_b, -1, 0, a);
      check("address ack", 16'(a), 16'(exp_ack ? ACK : NACK));
      if (exp_ack) begin
        byte_wr(vecs[k].reg_b, -1, 0, a);
        check("register ack", 16'(a), 16'(ACK));
        for (int j = 0; j < vecs[k].n_data; j++) begin
          byte_wr(vecs[k].data[23 - 8 * j -: 8], -1, 0, a);
          check("data ack", 16'(a), 16'(ACK));
        end
      end
      bus_stop();
      check("done pulses", 16'(done_cnt - d0), 16'(exp_ack ? 1 : 0));
      check("busy seen", 16'(busy_cyc > 0), 16'(exp_ack));
      if (!exp_ack) check("sda driven on mismatch", 16'(drive_cyc), 16'h0);
      check("write queue drained", 16'(wr_exp_q.size()), 16'h0);
    end

    // Single-byte read with NACK
    own_addr = 7'h50;
    cyc(2);
    r0 = rd_cnt;
    d0 = done_cnt;
    rd_ptr_q.push_back(8'h20);
    bus_start();
    byte_wr(8'hA0, -1, 0, a);
    byte_wr(8'h20, -1, 0, a);
    bus_rstart();
    byte_wr(8'hA1, -1, 0, a);
    check("read address ack", 16'(a), 16'(ACK));
    byte_rd(NACK, rb8);
    check("read byte", 16'(rb8), 16'h003C);
    check("released after nack", 16'(sda_oe), 16'h0);
    drive_cyc = 0;
    bus_stop();
    check("no drive during stop", 16'(drive_cyc), 16'h0);
    check("read requests", 16'(rd_cnt - r0), 16'h1);
    check("read done", 16'(done_cnt - d0), 16'h1);
    check("idle after read", 16'(state), 16'(S_IDLE));

    // Burst read across the pointer wrap
    r0 = rd_cnt;
    rd_ptr_q.push_back(8'hFE);
    rd_ptr_q.push_back(8'hFF);
    rd_ptr_q.push_back(8'h00);
    bus_start();
    byte_wr(8'hA0, -1, 0, a);
    byte_wr(8'hFE, -1, 0, a);
    bus_rstart();
    byte_wr(8'hA1, -1, 0, a);
    byte_rd(ACK, rb8);
    check("burst read 0", 16'(rb8), 16'h00E2);
    byte_rd(ACK, rb8);
    check("burst read 1", 16'(rb8), 16'h00E3);
    byte_rd(NACK, rb8);
    check("burst read 2", 16'(rb8), 16'h001C);
    bus_stop();
    check("burst read requests", 16'(rd_cnt - r0), 16'h3);
    check("read queue drained", 16'(rd_ptr_q.size()), 16'h0);

    // Glitches on SCL: 2-cycle low is filtered, 4-cycle low adds a bit
    w0 = wr_cnt;
    wr_exp_q.push_back({8'h30, 8'h96});
    bus_start();
    byte_wr(8'hA0, -1, 0, a);
    byte_wr(8'h30, -1, 0, a);
    byte_wr(8'h96, 4, 2, a);
    check("short glitch ack", 16'(a), 16'(ACK));
    bus_stop();
    check("short glitch writes", 16'(wr_cnt - w0), 16'h1);

    w0 = wr_cnt;
    wr_exp_q.push_back({8'h30, 8'h9B});
    bus_start();
    byte_wr(8'hA0, -1, 0, a);
    byte_wr(8'h30, -1, 0, a);
    byte_wr(8'h96, 4, 4, a);
    check("long glitch shifted ack", 16'(a), 16'(NACK));
    bus_stop();
    check("long glitch writes", 16'(wr_cnt - w0), 16'h1);
    check("glitch queue drained", 16'(wr_exp_q.size()), 16'h0);

    // Asynchronous reset while bit 3 of a read is on the bus
    rd_ptr_q.push_back(8'h1C);
    bus_start();
    byte_wr(8'hA0, -1, 0, a);
    byte_wr(8'h1C, -1, 0, a);
    bus_rstart();
    byte_wr(8'hA1, -1, 0, a);
    rb8 = '1;
    for (int i = 7; i >= 4; i--) begin
      bit_io(1'b1, 0, rb);
      rb8[i] = rb;
    end
    check("read upper nibble", 16'(rb8[7:4]), 16'h0);
    cyc(8);
    check("bit3 driven", 16'(sda_oe), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    check("reset releases sda", 16'(sda_oe), 16'h0);
    check("reset state mid-read", 16'(state), 16'(S_IDLE));
    check("reset clears ptr", 16'(reg_ptr), 16'h0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    bus_stop();
    check("reset read queue drained", 16'(rd_ptr_q.size()), 16'h0);

    // Enable loss mid-byte
    w0 = wr_cnt;
    d0 = done_cnt;
    bus_start();
    byte_wr(8'hA0, -1, 0, a);
    byte_wr(8'h60, -1, 0, a);
    for (int i = 7; i >= 4; i--) bit_io(1'b0, 0, rb);
    check("busy before disable", 16'(busy), 16'h1);
    enable = 1'b0;
    cyc(1);
    check("idle after disable", 16'(state), 16'(S_IDLE));
    check("busy after disable", 16'(busy), 16'h0);
    for (int i = 3; i >= 0; i--) bit_io(1'b1, 0, rb);
    bit_io(1'b1, 0, a);
    check("no ack while disabled", 16'(a), 16'(NACK));
    bus_stop();
    check("no writes while disabled", 16'(wr_cnt - w0), 16'h0);
    check("no done while disabled", 16'(done_cnt - d0), 16'h0);

    // Recovery after re-enable
    enable = 1'b1;
    cyc(4);
    wr_exp_q.push_back({8'h61, 8'h3E});
    bus_start();
    byte_wr(8'hA0, -1, 0, a);
    byte_wr(8'h61, -1, 0, a);
    byte_wr(8'h3E, -1, 0, a);
    check("recovery data ack", 16'(a), 16'(ACK));
    bus_stop();
    check("final queue drained", 16'(wr_exp_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target-side engine that responds to an external bus master on the open-drain SCL/SDA pair and sits beside the existing I2C master engine inside the I2C peripheral, selected when the control register's mode bit selects slave operation. It recognises its 7-bit address, accepts a one-byte register pointer, and then either delivers written bytes to the register interface or serves read bytes from it. Transactions use the same framing the master engine generates: address+W, register, data for writes; address+W, register, repeated START, address+R, data for reads. The register pointer auto-increments across multi-byte bursts.

## Interface
- FILTER_LEN, 3: consecutive identical samples required before a synchronised SCL/SDA level is accepted (range 1..15).
- clk_i  in  1  peripheral clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  slave mode; when 0, pins are released and the FSM is held in IDLE.
- own_addr_i  in  7  this target's bus address.
- scl_i / sda_i  in  1  raw pad inputs.
- scl_o / sda_o  out  1  pad output value; tied to 0 (open drain).
- scl_oe_o / sda_oe_o  out  1  1 pulls the line low.
- reg_ptr_o  out  8  current register pointer.
- wr_valid_o  out  1  one-cycle strobe: wdata_o is to be written at reg_ptr_o.
- wdata_o  out  8  received data byte.
- rd_req_o  out  1  one-cycle strobe: read byte needed from reg_ptr_o.
- rdata_i  in  8  read byte.
- rdata_valid_i  in  1  rdata_i is valid; used only with stretching enabled.
- busy_o  out  1  addressed transaction in progress (ADDR_ACK through STOP).
- done_o  out  1  one-cycle pulse on STOP that ends an addressed transaction.

## Operation
- Input path: two-flop synchroniser, then a FILTER_LEN glitch filter per line. Edge detectors on the filtered SCL/SDA produce scl_rise, scl_fall, start (SDA fall while SCL high) and stop (SDA rise while SCL high).
- START or repeated START from any state goes to ADDR with a cleared bit counter. STOP from any state goes to IDLE, releases both lines, and pulses done_o if busy_o was 1.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- ADDR: shifts 8 bits MSB first on scl_rise. If the upper 7 bits equal own_addr_i, go to ADDR_ACK; otherwise go to WAIT_STOP and never drive.
- ADDR_ACK: drives SDA low from the next scl_fall to the following scl_fall. For R/W=0, next state is REG. For R/W=1, pulse rd_req_o on entry, then go to RDATA.
- REG: receives 8 bits into reg_ptr_o, then REG_ACK (ACK), then WDATA.
- WDATA: receives 8 bits, then WDATA_ACK. On entry to WDATA_ACK, pulse wr_valid_o with wdata_o. Drive ACK. Increment reg_ptr_o by 1 after the ACK bit, wrapping 0xFF to 0x00. Return to WDATA.
- RDATA: the shift register loads rdata_i on the cycle after rd_req_o. The MSB is driven at the scl_fall ending ADDR_ACK/RDATA_ACK; the next bit is driven on each scl_fall. A bit value of 1 means SDA is released.
- RDATA_ACK: SDA is released and the master's ACK is sampled on scl_rise. On ACK, increment reg_ptr_o, pulse rd_req_o, and return to RDATA. On NACK, go to WAIT_STOP.
- WAIT_STOP: both lines released until START or STOP.
- When enable_i drops, the FSM goes to IDLE and releases both lines the next cycle.

## Timing
- Input latency: 2 synchroniser cycles + FILTER_LEN cycles. The master's clock divider must give SCL half-periods of at least FILTER_LEN+6 clk_i cycles.
- SDA changes only 1 cycle after a detected scl_fall, never while SCL is high, except when released by STOP/START/enable loss.
- rd_req_o to rdata_i sampling: 1 cycle (unstretched).
- Reset values: every *_oe_o = 0; scl_o = sda_o = 0; reg_ptr_o = 0; wdata_o = 0; wr_valid_o = rd_req_o = busy_o = done_o = 0; state IDLE. A mid-transfer reset releases the lines immediately, since reset is asynchronous.

## Configuration
- I2C_SLAVE_STRETCH_EN defined: after each rd_req_o, SCL is held low (scl_oe_o = 1) from the next scl_fall until rdata_valid_i is 1. rdata_i is captured on that cycle and SCL is released one cycle later.
- I2C_SLAVE_STRETCH_EN undefined: scl_oe_o is constant 0, rdata_valid_i is ignored, and rdata_i is captured 1 cycle after rd_req_o.

## Structure
- i2c_slave_pkg holds the state enum, the width localparams (ADDR_W = 7, BYTE_W = 8), and the ACK/NACK level constants.
- One sub-module, i2c_slave_filter (synchroniser + glitch filter + registered output), instantiated once for SCL and once for SDA.

## Test plan
- Write: own_addr 0x50; master sends 0xA0, 0x10, 0xA5, STOP -> three ACKs; wr_valid_o pulses once with reg_ptr_o = 0x10 and wdata_o = 0xA5; done_o pulses.
- Burst write: 0xA0, 0xFF, 0x11, 0x22 -> writes 0x11@0xFF, then 0x22@0x00 (pointer wrap).
- Read: 0xA0, 0x20, Sr, 0xA1; rdata_i = 0x3C; master NACK; STOP -> SDA carries 0 0 1 1 1 1 0 0; lines released after NACK; rd_req_o pulses once.
- Address mismatch: 0xA2 -> NACK (SDA never driven); no strobes; busy_o stays 0 until STOP.
- Glitch: with FILTER_LEN = 3, a 2-cycle SCL low pulse mid-byte -> bit counter unchanged. Repeat with a 4-cycle pulse -> counted.
- Reset/enable: assert rst_i during the RDATA bit 3 drive -> sda_oe_o drops the same cycle; enable_i = 0 mid-byte -> IDLE next cycle, no further strobes.
